// File: rtl/iob_dir_ctrl_if.sv
// Command and pin-control bundle between the PHY scheduler and the IOB direction sequencer.
interface iob_dir_ctrl_if #(
  parameter int NIBBLES = 9,
  parameter int BURST_W = 4
);
  logic                     cmd_valid;
  logic                     cmd_ready;
  logic                     cmd_wr;
  logic [BURST_W-1:0]       cmd_len;
  logic [NIBBLES-1:0]       cmd_nib_mask;
  logic [NIBBLES-1:0][5:0]  tx_t_out;
  logic [NIBBLES-1:0][5:0]  dyn_dci;
  logic [NIBBLES-1:0][5:0]  ibuf_disable;
  logic                     wr_data_en;
  logic                     rd_capture_en;
  logic                     burst_done;
  logic                     busy;

  modport master (
    output cmd_valid, cmd_wr, cmd_len, cmd_nib_mask,
    input  cmd_ready, tx_t_out, dyn_dci, ibuf_disable,
           wr_data_en, rd_capture_en, burst_done, busy
  );

  modport slave (
    input  cmd_valid, cmd_wr, cmd_len, cmd_nib_mask,
    output cmd_ready, tx_t_out, dyn_dci, ibuf_disable,
           wr_data_en, rd_capture_en, burst_done, busy
  );
endinterface

// File: rtl/iob_dir_ctrl.sv
// Per-burst direction/termination sequencer: walks IDLE->PRE->BURST->POST->GAP and
// drives tristate, DCI and IBUF controls plus beat strobes, all registered from next-state.
module iob_dir_ctrl #(
  parameter int NIBBLES       = 9,
  parameter int BURST_W       = 4,
  parameter int WR_PRE        = 1,
  parameter int WR_POST       = 1,
  parameter int RD_PRE        = 2,
  parameter int RD_POST       = 1,
  parameter int TURNAROUND    = 2,
  parameter int IBUF_IDLE_DIS = 1
) (
  input  logic             clk,
  input  logic             rst,
  iob_dir_ctrl_if.slave    bus
);

  typedef enum logic [2:0] {S_IDLE, S_PRE, S_BURST, S_POST, S_GAP} state_t;

  localparam logic [2:0] WR_PRE_C  = 3'(WR_PRE);
  localparam logic [2:0] WR_POST_C = 3'(WR_POST);
  localparam logic [2:0] RD_PRE_C  = 3'(RD_PRE);
  localparam logic [2:0] RD_POST_C = 3'(RD_POST);
  localparam logic [2:0] TA_C      = 3'(TURNAROUND);
  localparam logic [NIBBLES-1:0][5:0] PINS_ONE = '1;
  localparam logic [NIBBLES-1:0][5:0] IB_IDLE  = (IBUF_IDLE_DIS != 0) ? '1 : '0;

  state_t                   state_q, state_nxt;
  logic                     dir_q, dir_nxt;
  logic [NIBBLES-1:0]       mask_q, mask_nxt;
  logic [BURST_W-1:0]       len_q, len_nxt;
  logic [BURST_W-1:0]       beat_q, beat_nxt;
  logic [2:0]               phase_q, phase_nxt;
  logic                     accept;
  logic                     done_nxt;
  logic                     active_nxt;
  logic [NIBBLES-1:0][5:0]  tx_nxt, dci_nxt, ib_nxt;

  logic                     ready_q;
  logic [NIBBLES-1:0][5:0]  tx_q, dci_q, ib_q;
  logic                     wr_en_q, rd_en_q, done_q, busy_q;

  function automatic logic [2:0] pre_of(input logic wr);
    return wr ? WR_PRE_C : RD_PRE_C;
  endfunction

  function automatic logic [2:0] post_of(input logic wr);
    return wr ? WR_POST_C : RD_POST_C;
  endfunction

  assign accept = bus.cmd_valid && ready_q;

  // Next-state and counter update
  always_comb begin
    state_nxt = state_q;
    dir_nxt   = dir_q;
    mask_nxt  = mask_q;
    len_nxt   = len_q;
    beat_nxt  = beat_q;
    phase_nxt = phase_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          dir_nxt   = bus.cmd_wr;
          mask_nxt  = bus.cmd_nib_mask;
          len_nxt   = bus.cmd_len;
          beat_nxt  = '0;
          phase_nxt = '0;
          state_nxt = (pre_of(bus.cmd_wr) != 3'd0) ? S_PRE : S_BURST;
        end
      end
      S_PRE: begin
        if (phase_q == pre_of(dir_q) - 3'd1) begin
          state_nxt = S_BURST;
          beat_nxt  = '0;
        end else begin
          phase_nxt = phase_q + 3'd1;
        end
      end
      S_BURST: begin
        if (beat_q == len_q) begin
          phase_nxt = '0;
          if (post_of(dir_q) != 3'd0) state_nxt = S_POST;
          else if (TA_C != 3'd0)      state_nxt = S_GAP;
          else                        state_nxt = S_IDLE;
        end else begin
          beat_nxt = beat_q + 1'b1;
        end
      end
      S_POST: begin
        if (phase_q == post_of(dir_q) - 3'd1) begin
          phase_nxt = '0;
          state_nxt = (TA_C != 3'd0) ? S_GAP : S_IDLE;
        end else begin
          phase_nxt = phase_q + 3'd1;
        end
      end
      S_GAP: begin
        if (phase_q == TA_C - 3'd1) state_nxt = S_IDLE;
        else                        phase_nxt = phase_q + 3'd1;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Output decode from next-state so every registered output lines up with its state cycle
  always_comb begin
    done_nxt = ((state_nxt == S_POST) && (phase_nxt == post_of(dir_nxt) - 3'd1)) ||
               ((state_nxt == S_BURST) && (beat_nxt == len_nxt) && (post_of(dir_nxt) == 3'd0));
    active_nxt = (state_nxt == S_PRE) || (state_nxt == S_BURST) || (state_nxt == S_POST);
    tx_nxt  = PINS_ONE;
    dci_nxt = PINS_ONE;
    ib_nxt  = IB_IDLE;
    for (int i = 0; i < NIBBLES; i++) begin
      if (active_nxt && mask_nxt[i]) begin
        if (dir_nxt) begin
          tx_nxt[i] = 6'h00;
        end else begin
          dci_nxt[i] = 6'h00;
          ib_nxt[i]  = 6'h00;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      dir_q   <= 1'b0;
      mask_q  <= '0;
      len_q   <= '0;
      beat_q  <= '0;
      phase_q <= '0;
      ready_q <= 1'b0;
      tx_q    <= PINS_ONE;
      dci_q   <= PINS_ONE;
      ib_q    <= IB_IDLE;
      wr_en_q <= 1'b0;
      rd_en_q <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_nxt;
      dir_q   <= dir_nxt;
      mask_q  <= mask_nxt;
      len_q   <= len_nxt;
      beat_q  <= beat_nxt;
      phase_q <= phase_nxt;
      ready_q <= (state_nxt == S_IDLE);
      tx_q    <= tx_nxt;
      dci_q   <= dci_nxt;
      ib_q    <= ib_nxt;
      wr_en_q <= (state_nxt == S_BURST) && dir_nxt;
      rd_en_q <= (state_nxt == S_BURST) && !dir_nxt;
      done_q  <= done_nxt;
      busy_q  <= (state_nxt != S_IDLE);
    end
  end

  assign bus.cmd_ready     = ready_q;
  assign bus.tx_t_out      = tx_q;
  assign bus.dyn_dci       = dci_q;
  assign bus.ibuf_disable  = ib_q;
  assign bus.wr_data_en    = wr_en_q;
  assign bus.rd_capture_en = rd_en_q;
  assign bus.burst_done    = done_q;
  assign bus.busy          = busy_q;

endmodule

// File: tb/tb_iob_dir_ctrl.sv
// Directed bench for iob_dir_ctrl: default-parameter instance plus a zero-pre/post/gap instance.
module tb_iob_dir_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   rd_cnt, done_cnt;
  logic [53:0] ones = '1;
  logic [53:0] contention;

  always #5 clk = ~clk;

  iob_dir_ctrl_if #(.NIBBLES(9), .BURST_W(4)) bus0 ();
  iob_dir_ctrl_if #(.NIBBLES(9), .BURST_W(4)) bus1 ();

  iob_dir_ctrl u0 (.clk(clk), .rst(rst), .bus(bus0));

  iob_dir_ctrl #(.WR_PRE(0), .WR_POST(0), .TURNAROUND(0)) u1 (.clk(clk), .rst(rst), .bus(bus1));

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chkp(input string tag, input logic [53:0] obs, input logic [53:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // 6 ones per selected nibble
  function automatic logic [53:0] ex(input logic [8:0] m);
    logic [53:0] r;
    r = '0;
    for (int i = 0; i < 9; i++) r[i*6 +: 6] = m[i] ? 6'h3F : 6'h00;
    return r;
  endfunction

  task automatic pins0(input string tag, input logic [53:0] tx_e, input logic [53:0] dci_e,
                       input logic [53:0] ib_e);
    chkp({tag, "_tx"},   bus0.tx_t_out,     tx_e);
    chkp({tag, "_dci"},  bus0.dyn_dci,      dci_e);
    chkp({tag, "_ibuf"}, bus0.ibuf_disable, ib_e);
  endtask

  initial begin
    bus0.cmd_valid = 1'b0; bus0.cmd_wr = 1'b0; bus0.cmd_len = '0; bus0.cmd_nib_mask = '0;
    bus1.cmd_valid = 1'b0; bus1.cmd_wr = 1'b0; bus1.cmd_len = '0; bus1.cmd_nib_mask = '0;
    repeat (2) tick();

    chk1("rst_ready", bus0.cmd_ready, 1'b0);
    chk1("rst_busy", bus0.busy, 1'b0);
    chk1("rst_wr_en", bus0.wr_data_en, 1'b0);
    pins0("rst", ones, ones, ones);
    rst = 1'b0;
    #1 chk1("ready_before_first_clk", bus0.cmd_ready, 1'b0);
    tick();
    chk1("ready_after_release", bus0.cmd_ready, 1'b1);

    // write, len=3, nibble 0
    bus0.cmd_valid = 1'b1; bus0.cmd_wr = 1'b1; bus0.cmd_len = 4'd3; bus0.cmd_nib_mask = 9'h001;
    tick();
    bus0.cmd_valid = 1'b0;
    pins0("t1_pre", ~ex(9'h001), ones, ones);
    chk1("t1_pre_wr_en", bus0.wr_data_en, 1'b0);
    chk1("t1_pre_busy", bus0.busy, 1'b1);
    chk1("t1_pre_ready", bus0.cmd_ready, 1'b0);
    tick();
    for (int i = 0; i < 4; i++) begin
      chk1("t1_burst_wr_en", bus0.wr_data_en, 1'b1);
      chk1("t1_burst_done", bus0.burst_done, 1'b0);
      chkp("t1_burst_tx", bus0.tx_t_out, ~ex(9'h001));
      tick();
    end
    chk1("t1_post_done", bus0.burst_done, 1'b1);
    chk1("t1_post_wr_en", bus0.wr_data_en, 1'b0);
    pins0("t1_post", ~ex(9'h001), ones, ones);
    tick();
    pins0("t1_gap1", ones, ones, ones);
    chk1("t1_gap1_busy", bus0.busy, 1'b1);
    chk1("t1_gap1_done", bus0.burst_done, 1'b0);
    tick();
    chk1("t1_gap2_ready", bus0.cmd_ready, 1'b0);
    tick();
    chk1("t1_idle_ready", bus0.cmd_ready, 1'b1);
    chk1("t1_idle_busy", bus0.busy, 1'b0);

    // read, len=0, all nibbles
    bus0.cmd_valid = 1'b1; bus0.cmd_wr = 1'b0; bus0.cmd_len = 4'd0; bus0.cmd_nib_mask = 9'h1FF;
    tick();
    bus0.cmd_valid = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      pins0("t2_active", ones, '0, '0);
      chk1("t2_rd_cap", bus0.rd_capture_en, i == 3);
      chk1("t2_done", bus0.burst_done, i == 4);
      chk1("t2_wr_en", bus0.wr_data_en, 1'b0);
      tick();
    end
    pins0("t2_gap", ones, ones, ones);
    tick(); tick();
    chk1("t2_idle_ready", bus0.cmd_ready, 1'b1);

    // write then a queued read with cmd_valid held high
    bus0.cmd_valid = 1'b1; bus0.cmd_wr = 1'b1; bus0.cmd_len = 4'd0; bus0.cmd_nib_mask = 9'h0F0;
    tick();
    bus0.cmd_wr = 1'b0;
    for (int i = 1; i <= 13; i++) begin
      contention = ~bus0.tx_t_out & ~bus0.dyn_dci;
      chkp("t3_no_contention", contention, '0);
      chk1("t3_strobe_excl", bus0.wr_data_en & bus0.rd_capture_en, 1'b0);
      if (i <= 5) chk1("t3_ready_low", bus0.cmd_ready, 1'b0);
      if (i == 6) chk1("t3_ready_after_gap", bus0.cmd_ready, 1'b1);
      if (i == 2) chk1("t3_wr_beat", bus0.wr_data_en, 1'b1);
      if (i == 7) begin
        pins0("t3_rd_pre", ones, ~ex(9'h0F0), ~ex(9'h0F0));
        bus0.cmd_valid = 1'b0;
      end
      if (i == 9) chk1("t3_rd_beat", bus0.rd_capture_en, 1'b1);
      if (i == 13) chk1("t3_final_ready", bus0.cmd_ready, 1'b1);
      tick();
    end

    // read with empty mask, len=2
    bus0.cmd_valid = 1'b1; bus0.cmd_wr = 1'b0; bus0.cmd_len = 4'd2; bus0.cmd_nib_mask = 9'h000;
    tick();
    bus0.cmd_valid = 1'b0;
    rd_cnt = 0; done_cnt = 0;
    for (int i = 1; i <= 8; i++) begin
      pins0("t6_idle_pins", ones, ones, ones);
      if (bus0.rd_capture_en) rd_cnt++;
      if (bus0.burst_done) done_cnt++;
      tick();
    end
    chkp("t6_rd_count", 54'(rd_cnt), 54'd3);
    chkp("t6_done_count", 54'(done_cnt), 54'd1);
    chk1("t6_ready", bus0.cmd_ready, 1'b1);

    // zero-pre/post/gap instance, 16-beat write
    bus1.cmd_valid = 1'b1; bus1.cmd_wr = 1'b1; bus1.cmd_len = 4'd15; bus1.cmd_nib_mask = 9'h001;
    tick();
    bus1.cmd_valid = 1'b0;
    chkp("t4_first_tx", bus1.tx_t_out, ~ex(9'h001));
    for (int i = 1; i <= 16; i++) begin
      chk1("t4_wr_en", bus1.wr_data_en, 1'b1);
      chk1("t4_done", bus1.burst_done, i == 16);
      tick();
    end
    chk1("t4_end_wr_en", bus1.wr_data_en, 1'b0);
    chk1("t4_end_ready", bus1.cmd_ready, 1'b1);
    chk1("t4_end_busy", bus1.busy, 1'b0);
    chkp("t4_end_tx", bus1.tx_t_out, ones);

    // asynchronous reset in the middle of a write burst
    bus0.cmd_valid = 1'b1; bus0.cmd_wr = 1'b1; bus0.cmd_len = 4'd7; bus0.cmd_nib_mask = 9'h1FF;
    tick();
    bus0.cmd_valid = 1'b0;
    tick(); tick();
    chk1("t5_mid_burst", bus0.wr_data_en, 1'b1);
    #2 rst = 1'b1;
    #1;
    chkp("t5_rst_tx", bus0.tx_t_out, ones);
    chk1("t5_rst_wr_en", bus0.wr_data_en, 1'b0);
    chk1("t5_rst_busy", bus0.busy, 1'b0);
    chk1("t5_rst_ready", bus0.cmd_ready, 1'b0);
    tick(); tick();
    rst = 1'b0;
    tick();
    chk1("t5_release_ready", bus0.cmd_ready, 1'b1);
    bus0.cmd_valid = 1'b1; bus0.cmd_wr = 1'b0; bus0.cmd_len = 4'd1; bus0.cmd_nib_mask = 9'h003;
    tick();
    bus0.cmd_valid = 1'b0;
    pins0("t5_rd_pre", ones, ~ex(9'h003), ~ex(9'h003));
    chk1("t5_rd_pre_cap", bus0.rd_capture_en, 1'b0);
    tick(); tick();
    chk1("t5_rd_beat0", bus0.rd_capture_en, 1'b1);
    tick();
    chk1("t5_rd_beat1", bus0.rd_capture_en, 1'b1);
    tick();
    chk1("t5_rd_post_done", bus0.burst_done, 1'b1);
    chk1("t5_rd_post_cap", bus0.rd_capture_en, 1'b0);
    tick();
    pins0("t5_gap", ones, ones, ones);
    tick(); tick();
    chk1("t5_idle_ready", bus0.cmd_ready, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
